// File: rtl/full_adder.sv
// ============================================================================
//  Module   : full_adder
//  Purpose  : WIDTH-bit ripple-carry adder with combinational and registered
//             {Cout, Sum, Ovf} result views.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
    output logic             Ovf_q
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] w_sum_d;
    logic             w_cout_d;
    logic             w_ovf_d;

    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q;
    logic             r_ovf_q;

    assign w_carry[0] = Cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign w_sum[gi]     = A[gi] ^ B[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (A[gi] & B[gi])
                                 | (A[gi] & w_carry[gi])
                                 | (B[gi] & w_carry[gi]);
        end
    endgenerate

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    always_comb begin
        w_sum_d  = w_sum;
        w_cout_d = w_carry[WIDTH];
        w_ovf_d  = w_carry[WIDTH-1] ^ w_carry[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_q  <= '0;
            r_cout_q <= 1'b0;
            r_ovf_q  <= 1'b0;
        end else begin
            r_sum_q  <= w_sum_d;
            r_cout_q <= w_cout_d;
            r_ovf_q  <= w_ovf_d;
        end
    end

    assign Sum    = w_sum_d;
    assign Cout   = w_cout_d;
    assign Ovf    = w_ovf_d;
    assign Sum_q  = r_sum_q;
    assign Cout_q = r_cout_q;
    assign Ovf_q  = r_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
//  Module   : tb_full_adder
//  Purpose  : Directed self-checking bench for full_adder at WIDTH=1 and 8.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_adder;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, c1;
    logic       s1, co1, ov1, s1_q, co1_q, ov1_q;

    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8, s8_q;
    logic       co8, ov8, co8_q, ov8_q;

    int n_chk;
    int n_pass;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a1),
        .B     (b1),
        .Cin   (c1),
        .Sum   (s1),
        .Cout  (co1),
        .Ovf   (ov1),
        .Sum_q (s1_q),
        .Cout_q(co1_q),
        .Ovf_q (ov1_q)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a8),
        .B     (b8),
        .Cin   (c8),
        .Sum   (s8),
        .Cout  (co8),
        .Ovf   (ov8),
        .Sum_q (s8_q),
        .Cout_q(co8_q),
        .Ovf_q (ov8_q)
    );

    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Hand-computed {Cout,Sum} for {A,B,Cin} = 0..7
    logic [1:0] exp_tab [8];
    logic [9:0] ref8;
    logic       ref_ovf;
    logic [2:0] v;

    initial begin
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        n_chk = 0;
        n_pass = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        a1 = 0; b1 = 0; c1 = 0;
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

        #1;
        chk("reset_regs1", {7'd0, s1_q, co1_q, ov1_q}, 10'd0);
        chk("reset_regs8", {s8_q, co8_q, ov8_q}, 10'd0);
        chk("zero_comb8", {s8, co8, ov8}, 10'd0);

        // Truth table with clock idle
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {a1, b1, c1} = v;
            #10;
            chk("truth_cout_sum", {8'd0, co1, s1}, {8'd0, exp_tab[i]});
            chk("truth_ovf", {9'd0, ov1}, {9'd0, c1 ^ exp_tab[i][1]});
        end

        // Reset held while clock toggles
        a1 = 1; b1 = 1; c1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_reset_regs", {7'd0, s1_q, co1_q, ov1_q}, 10'd0);
        end
        chk("held_reset_comb", {8'd0, co1, s1}, 10'b11);

        // Release reset, first capture on next edge
        rst_n = 1'b1;
        a1 = 0; b1 = 1; c1 = 1;
        #1;
        chk("pre_edge_regs", {7'd0, s1_q, co1_q, ov1_q}, 10'd0);
        tick();
        chk("first_capture", {7'd0, s1_q, co1_q, ov1_q}, 10'b010);

        // Mid-operation asynchronous reset
        a1 = 1; b1 = 0; c1 = 0;
        tick();
        chk("pre_midreset", {7'd0, s1_q, co1_q, ov1_q}, 10'b100);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_regs", {7'd0, s1_q, co1_q, ov1_q}, 10'd0);
        chk("midreset_comb", {8'd0, co1, s1}, 10'b01);
        #2 rst_n = 1'b1;

        // WIDTH=8 boundary vectors
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
        #1;
        chk("ff_plus_1_comb", {s8, co8, ov8}, {8'h00, 1'b1, 1'b0});
        tick();
        chk("ff_plus_1_reg", {s8_q, co8_q, ov8_q}, {8'h00, 1'b1, 1'b0});

        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        #1;
        chk("7f_plus_1_comb", {s8, co8, ov8}, {8'h80, 1'b0, 1'b1});
        tick();
        chk("7f_plus_1_reg", {s8_q, co8_q, ov8_q}, {8'h80, 1'b0, 1'b1});

        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1;
        chk("all_ones_comb", {s8, co8, ov8}, {8'hFF, 1'b1, 1'b0});
        tick();
        chk("all_ones_reg", {s8_q, co8_q, ov8_q}, {8'hFF, 1'b1, 1'b0});

        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
        #1;
        chk("neg_ovf_comb", {s8, co8, ov8}, {8'h00, 1'b1, 1'b1});

        // Random vectors: combinational now, registered after one edge
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            ref8    = {1'b0, 9'({1'b0, a8} + {1'b0, b8} + {8'd0, c8})};
            ref_ovf = (a8[7] == b8[7]) && (ref8[7] != a8[7]);
            #1;
            chk("rand_comb", {s8, co8, ov8}, {ref8[7:0], ref8[8], ref_ovf});
            tick();
            chk("rand_reg", {s8_q, co8_q, ov8_q}, {ref8[7:0], ref8[8], ref_ovf});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/full_adder.md
Name: full_adder

Overview:
- Ripple-carry binary adder: A + B + Cin -> {Cout, Sum}. Default width is 1 bit, which makes it the classic one-bit full adder cell.
- Provides two result views:
  - a purely combinational result, with no clock dependence;
  - a registered copy of that result, captured on the clock.
- Used as a leaf arithmetic cell and as the building block for wider datapath adders.

Parameters:
- WIDTH, 1, operand and sum width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- rst_n  input  1  asynchronous active-low reset; clears only the registered outputs.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry in.
- Sum  output  WIDTH  combinational sum bits, (A+B+Cin) mod 2^WIDTH.
- Cout  output  1  combinational carry out, bit WIDTH of A+B+Cin.
- Ovf  output  1  combinational signed overflow: carry into MSB XOR carry out of MSB.
- Sum_q  output  WIDTH  Sum registered on rising clk.
- Cout_q  output  1  Cout registered on rising clk.
- Ovf_q  output  1  Ovf registered on rising clk.

Behaviour:
- Bit cell i, with c[0]=Cin:
  - s[i] = A[i] ^ B[i] ^ c[i];
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i]).
- Cells are chained as a ripple structure through a generate loop. Sum = s, Cout = c[WIDTH], Ovf = c[WIDTH-1] ^ c[WIDTH].
- For WIDTH=1, c[0] is Cin, so Ovf = Cin ^ Cout.
- Combinational outputs (Sum, Cout, Ovf):
  - zero-cycle latency; settle after any input change with no clock edge required;
  - independent of clk and rst_n, including during reset;
  - contain no latches.
- Registered outputs (Sum_q, Cout_q, Ovf_q):
  - latency is exactly one clock; the values present at a rising clk edge appear after that edge;
  - no enable; a new value is captured every edge.
- Reset:
  - rst_n low immediately forces Sum_q=0, Cout_q=0, Ovf_q=0, with no clock required;
  - while rst_n is low, the registers hold 0 regardless of clk;
  - the first capture occurs on the first rising clk edge after rst_n goes high;
  - rst_n asserted mid-operation clears the registers at once; the combinational outputs continue to track the inputs.
- Boundary conditions:
  - all-ones + all-ones + 1 gives Sum = all-ones, Cout=1;
  - wrap-around is modulo 2^WIDTH, and the carry is reported on Cout;
  - 0+0+0 gives all outputs 0.
- X/Z on any input bit may propagate X to the dependent outputs. No X-masking is required.

Test Plan:
- WIDTH=1, clk idle, rst_n unspecified, apply all 8 {A,B,Cin} combos at 10 ns spacing -> Sum/Cout respectively 00 (000), 10 (001), 10 (010), 01 (011), 10 (100), 01 (101), 01 (110), 11 (111), each valid before the next change.
- WIDTH=1, rst_n=0, A=1 B=1 Cin=1, toggle clk -> Sum_q=Cout_q=Ovf_q=0 throughout; Sum=1, Cout=1 combinationally.
- WIDTH=1, rst_n rises, then A=0 B=1 Cin=1 before a rising edge -> after that edge Sum_q=0, Cout_q=1; before the edge Sum_q still 0.
- Registered mid-operation reset: with Sum_q=1 held, drop rst_n between edges -> Sum_q, Cout_q, Ovf_q go 0 immediately, not at the next edge.
- WIDTH=8:
  - A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1, Ovf=0;
  - A=8'h7F, B=8'h01, Cin=0 -> Sum=8'h80, Cout=0, Ovf=1;
  - registered copies match one clock later.
- WIDTH=8, randomized A/B/Cin for 1000 cycles -> {Cout,Sum} equals A+B+Cin every cycle; {Cout_q,Sum_q} equals the previous cycle's value.
